// File: rtl/ftdi_fifo_device_model.sv
// FT245-style asynchronous FIFO device model: the chip side of the FTDI FIFO bus,
// with host-side byte streams that feed the RX FIFO and drain the TX FIFO.
module ftdi_fifo_device_model #(
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int RD_DATA_DLY = 2,
  parameter int PRECHARGE   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      oFIFO_RXF_n,
  input  logic                      iFIFO_RD_n,
  output logic [7:0]                oFIFO_DATA,
  output logic                      oFIFO_DATA_OE,
  output logic                      oFIFO_TXE_n,
  input  logic                      iFIFO_WR_n,
  input  logic [7:0]                iFIFO_DATA,
  input  logic                      iHOST_VALID,
  input  logic [7:0]                iHOST_DATA,
  output logic                      oHOST_READY,
  output logic                      oHOST_VALID,
  output logic [7:0]                oHOST_DATA,
  input  logic                      iHOST_READY,
  output logic [$clog2(RX_DEPTH):0] oRX_LEVEL,
  output logic [$clog2(TX_DEPTH):0] oTX_LEVEL,
  output logic                      oERR,
  input  logic                      iERR_CLR
);

  localparam int RX_AW   = $clog2(RX_DEPTH);
  localparam int TX_AW   = $clog2(TX_DEPTH);
  localparam int CNT_MAX = (RD_DATA_DLY > PRECHARGE) ? RD_DATA_DLY : PRECHARGE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DLY_LD  = CNT_W'(RD_DATA_DLY);
  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRECHARGE);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD, R_PRE} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_PRE} wr_state_t;

  // RX FIFO (host -> FPGA); pointers carry one extra bit so full is distinct from empty
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;
  logic           rx_push, rx_pop, rx_full, rx_empty;

  assign oRX_LEVEL   = rx_wr_ptr - rx_rd_ptr;
  assign rx_full     = (oRX_LEVEL == (RX_AW + 1)'(RX_DEPTH));
  assign rx_empty    = (oRX_LEVEL == '0);
  assign oHOST_READY = !rx_full;
  assign rx_push     = iHOST_VALID && oHOST_READY;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= iHOST_DATA;
  end

  // TX FIFO (FPGA -> host), first-word fall-through toward the host
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr;
  logic           tx_push, tx_pop, tx_full, tx_empty;

  assign oTX_LEVEL   = tx_wr_ptr - tx_rd_ptr;
  assign tx_full     = (oTX_LEVEL == (TX_AW + 1)'(TX_DEPTH));
  assign tx_empty    = (oTX_LEVEL == '0);
  assign oHOST_VALID = !tx_empty;
  assign oHOST_DATA  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign tx_pop      = oHOST_VALID && iHOST_READY;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= iFIFO_DATA;
  end

  // Strobe edge detectors; reset low so a strobe held low through reset is not an edge
  logic prev_rd, prev_wr, rd_fall, wr_fall, live;

  assign rd_fall = prev_rd && !iFIFO_RD_n;
  assign wr_fall = prev_wr && !iFIFO_WR_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_rd <= 1'b0;
      prev_wr <= 1'b0;
      live    <= 1'b0;
    end else begin
      prev_rd <= iFIFO_RD_n;
      prev_wr <= iFIFO_WR_n;
      live    <= 1'b1;
    end
  end

  // Read FSM: state register
  rd_state_t        rd_state, rd_state_nxt;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic             rd_load, rd_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= R_IDLE;
      rd_cnt     <= '0;
      oFIFO_DATA <= 8'h00;
    end else begin
      rd_state <= rd_state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      if (rd_load) oFIFO_DATA <= rx_mem[rx_rd_ptr[RX_AW-1:0]];
    end
  end

  // Read FSM: next state
  always_comb begin
    rd_state_nxt = rd_state;
    rd_cnt_nxt   = rd_cnt;
    unique case (rd_state)
      R_IDLE: if (rd_fall && !rx_empty) begin
        rd_state_nxt = R_WAIT;
        rd_cnt_nxt   = DLY_LD;
      end
      R_WAIT: if (iFIFO_RD_n) begin
        rd_state_nxt = R_PRE;
        rd_cnt_nxt   = PRE_LD;
      end else if (rd_cnt == CNT_ONE) begin
        rd_state_nxt = R_HOLD;
      end else begin
        rd_cnt_nxt = rd_cnt - 1'b1;
      end
      R_HOLD: if (iFIFO_RD_n) begin
        rd_state_nxt = R_PRE;
        rd_cnt_nxt   = PRE_LD;
      end
      R_PRE: if (rd_cnt == CNT_ONE) begin
        rd_state_nxt = R_IDLE;
      end else begin
        rd_cnt_nxt = rd_cnt - 1'b1;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    oFIFO_RXF_n   = !(((rd_state == R_IDLE) && !rx_empty) ||
                      (rd_state == R_WAIT) || (rd_state == R_HOLD));
    oFIFO_DATA_OE = (rd_state == R_WAIT) || (rd_state == R_HOLD);
    rx_pop        = (rd_state == R_HOLD) && iFIFO_RD_n;
    rd_load       = (rd_state == R_WAIT) && !iFIFO_RD_n && (rd_cnt == CNT_ONE);
    rd_err        = ((rd_state == R_WAIT) && iFIFO_RD_n) ||
                    (rd_fall && ((rd_state == R_PRE) || ((rd_state == R_IDLE) && rx_empty)));
  end

  // Write FSM: state register
  wr_state_t        wr_state, wr_state_nxt;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
  logic             wr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_cnt   <= wr_cnt_nxt;
    end
  end

  // Write FSM: next state
  always_comb begin
    wr_state_nxt = wr_state;
    wr_cnt_nxt   = wr_cnt;
    unique case (wr_state)
      W_IDLE: if (wr_fall && !oFIFO_TXE_n) wr_state_nxt = W_BUSY;
      W_BUSY: if (iFIFO_WR_n) begin
        wr_state_nxt = W_PRE;
        wr_cnt_nxt   = PRE_LD;
      end
      W_PRE: if (wr_cnt == CNT_ONE) begin
        wr_state_nxt = W_IDLE;
      end else begin
        wr_cnt_nxt = wr_cnt - 1'b1;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM: outputs; TXE_n stays high for the reset cycle itself
  always_comb begin
    oFIFO_TXE_n = !(live && (wr_state == W_IDLE) && !tx_full);
    tx_push     = (wr_state == W_IDLE) && wr_fall && !oFIFO_TXE_n;
    wr_err      = wr_fall && oFIFO_TXE_n;
  end

  // Sticky protocol error; a new violation wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                  oERR <= 1'b0;
    else if (rd_err || wr_err) oERR <= 1'b1;
    else if (iERR_CLR)        oERR <= 1'b0;
  end

endmodule

// File: doc/ftdi_fifo_device_model.md
Name: ftdi_fifo_device_model

Overview:
Synthesizable FT245-style asynchronous-FIFO device model: the chip side of the FTDI FIFO interface. It drives RXF_n/TXE_n and read data, and responds to RD_n/WR_n strobes from the FPGA-side instream/outstream logic. Host-side Avalon-ST ports inject bytes toward the FPGA and drain bytes the FPGA wrote. It is used for on-chip loopback and simulation of the Android-to-FPGA link without the USB chip.

Parameters:
RX_DEPTH, 16, host-to-FPGA byte FIFO depth; power of 2, at least 2
TX_DEPTH, 16, FPGA-to-host byte FIFO depth; power of 2, at least 2
RD_DATA_DLY, 2, cycles from RD_n falling to read data valid; at least 1
PRECHARGE, 4, cycles RXF_n/TXE_n stay high after a strobe ends; at least 1

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
oFIFO_RXF_n  out  1  low = byte available to read
iFIFO_RD_n  in  1  read strobe, active low
oFIFO_DATA  out  8  read data toward FPGA
oFIFO_DATA_OE  out  1  high while device drives the read data bus
oFIFO_TXE_n  out  1  low = space available to write
iFIFO_WR_n  in  1  write strobe, active low
iFIFO_DATA  in  8  write data from FPGA
iHOST_VALID  in  1  host inject byte valid
iHOST_DATA  in  8  host inject byte
oHOST_READY  out  1  RX FIFO not full
oHOST_VALID  out  1  TX FIFO not empty
oHOST_DATA  out  8  TX FIFO head byte (first-word fall-through)
iHOST_READY  in  1  host drains byte
oRX_LEVEL  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
oTX_LEVEL  out  clog2(TX_DEPTH)+1  TX FIFO occupancy
oERR  out  1  sticky protocol-violation flag
iERR_CLR  in  1  clears oERR

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. After the first rising edge with rst high:
  - Both FIFOs are empty and both FSMs are in IDLE.
  - oFIFO_RXF_n=1, oFIFO_TXE_n=1, oFIFO_DATA=0x00, oFIFO_DATA_OE=0.
  - oHOST_READY=1, oHOST_VALID=0, oHOST_DATA=0x00, both levels=0, oERR=0.
- Strobe edge detectors: prev_rd and prev_wr registers reset to 0. An RD_n or WR_n held low across reset produces no strobe until it is sampled high and then low again.
- Host inject: push on iHOST_VALID && oHOST_READY. oHOST_READY = !rx_full, with no bypass of a same-cycle pop.
- Host drain: pop on oHOST_VALID && iHOST_READY.
- Each FIFO supports a simultaneous push and pop in one cycle; level is unchanged.
- Read FSM states: R_IDLE, R_WAIT, R_HOLD, R_PRE.
  - oFIFO_RXF_n = !((R_IDLE && rx_level!=0) || R_WAIT || R_HOLD), decoded from registered state only.
  - R_IDLE -> R_WAIT: RD_n falling edge sampled at edge M with RXF_n low. Counter loads RD_DATA_DLY; oFIFO_DATA_OE=1 from edge M.
  - R_WAIT -> R_HOLD: at edge M+RD_DATA_DLY, oFIFO_DATA <= RX head.
  - R_HOLD -> R_PRE: RD_n sampled high at edge K. RX pops at K; oFIFO_DATA_OE=0; oFIFO_DATA holds its value.
  - R_PRE -> R_IDLE: after PRECHARGE cycles, at edge K+PRECHARGE.
  - RD_n high while in R_WAIT: oERR set, no pop, go to R_PRE.
  - RD_n falling edge in R_PRE, or in R_IDLE while empty: oERR set, strobe ignored.
- Write FSM states: W_IDLE, W_BUSY, W_PRE.
  - oFIFO_TXE_n = !(W_IDLE && !tx_full).
  - W_IDLE -> W_BUSY: WR_n falling edge sampled at edge M with TXE_n low. iFIFO_DATA sampled at that same edge is pushed.
  - W_BUSY -> W_PRE: WR_n sampled high.
  - W_PRE -> W_IDLE: after PRECHARGE cycles.
  - WR_n falling edge while TXE_n is high: byte dropped, oERR set.
- oERR: set has priority over iERR_CLR in the same cycle.
- Pointers wrap modulo depth. Level width is clog2(DEPTH)+1 so that "full" is representable.

Test Plan:
- Reset check: assert rst for 2 cycles -> RXF_n=1, TXE_n=1, oHOST_READY=1, oHOST_VALID=0, levels=0, oERR=0.
- Read sequence: inject 0xA5 then 0x5A. RD_n low at edge 10, high at edge 13 -> oFIFO_DATA=0xA5 at edge 12; RXF_n high for edges 13..16, low again from edge 17. Second read returns 0x5A. RXF_n then stays high and rx_level=0.
- TX full: with TX_DEPTH=8, issue 8 WR_n pulses writing 0x11..0x18 -> TXE_n stays high once full. A 9th pulse writing 0x19 is dropped and oERR=1. Host drains 0x11..0x18 in order.
- Early read release: RD_n high one cycle after falling (RD_DATA_DLY=2) -> oERR=1, rx_level unchanged. The next full read returns the same byte.
- Reset mid-read: assert rst in R_WAIT while RD_n is held low -> FIFOs empty, RXF_n=1. Inject 0x3C with RD_n still low -> no read starts until RD_n goes high then low.
- RX full: fill RX to RX_DEPTH -> oHOST_READY=0 and the inject is not accepted, even in the same cycle as an RD_n-rising pop. oHOST_READY=1 the following cycle.
